copro_exec_scheduler: RTL and testbench

COPRO_EXEC_SCHEDULER -- requirements
Module: copro_exec_scheduler

---
 rtl/copro_exec_if.sv | 47 ++++
 rtl/copro_exec_scheduler.sv | 137 +++++++++++++
 tb/tb_copro_exec_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/copro_exec_if.sv
// Scheduler-facing bundle: CV-X-IF issue/commit/result channels plus the
// shared execution-unit handshake.
interface copro_exec_if #(
    parameter int XLEN = 32,
    parameter int ID_W = 3
);
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [ID_W-1:0] issue_id_i;
    logic [4:0]      issue_rd_i;
    logic [XLEN-1:0] issue_rs1_i;
    logic [XLEN-1:0] issue_rs2_i;
    logic            issue_we_i;

    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;

    logic            eu_start_o;
    logic [XLEN-1:0] eu_op_a_o;
    logic [XLEN-1:0] eu_op_b_o;
    logic            eu_done_i;
    logic [XLEN-1:0] eu_result_i;

    logic            result_valid_o;
    logic            result_ready_i;
    logic [ID_W-1:0] result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic [XLEN-1:0] result_data_o;

    modport slave (
        input  issue_valid_i, issue_id_i, issue_rd_i, issue_rs1_i, issue_rs2_i, issue_we_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  eu_done_i, eu_result_i, result_ready_i,
        output issue_ready_o, eu_start_o, eu_op_a_o, eu_op_b_o,
        output result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o
    );

    modport master (
        output issue_valid_i, issue_id_i, issue_rd_i, issue_rs1_i, issue_rs2_i, issue_we_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output eu_done_i, eu_result_i, result_ready_i,
        input  issue_ready_o, eu_start_o, eu_op_a_o, eu_op_b_o,
        input  result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o
    );
endinterface

// File: rtl/copro_exec_scheduler.sv
// In-order coprocessor scheduler: queues issued instructions, waits for each
// head to be committed or killed, runs it on the shared EU, returns results.
module copro_exec_scheduler #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ID_W  = 3
) (
    input logic         clk_i,
    input logic         rst_ni,
    copro_exec_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            we;
        logic            committed;
        logic            killed;
    } entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    entry_t           q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [XLEN-1:0]  res_q;
    state_t           state_q, state_d;

    logic             push, pop, start, res_ld, has_head, new_hit, op_live, rv;
    logic [DEPTH-1:0] ent_vld;
    entry_t           head;

    assign head     = q[head_q];
    assign has_head = (count_q != '0);
    assign bus.issue_ready_o = (count_q < CNT_W'(DEPTH));
    assign push     = bus.issue_valid_i && bus.issue_ready_o;
    assign new_hit  = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++)
            ent_vld[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.commit_valid_i && ent_vld[i] && (q[i].id == bus.commit_id_i)) begin
                    if (bus.commit_kill_i) q[i].killed    <= 1'b1;
                    else                   q[i].committed <= 1'b1;
                end
            end
            // The tail slot is never live while push is possible, so this write
            // cannot collide with the commit update above.
            if (push) begin
                q[tail_q] <= '{id:        bus.issue_id_i,
                               rd:        bus.issue_rd_i,
                               rs1:       bus.issue_rs1_i,
                               rs2:       bus.issue_rs2_i,
                               we:        bus.issue_we_i,
                               committed: new_hit && !bus.commit_kill_i,
                               killed:    new_hit &&  bus.commit_kill_i};
                tail_q <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (res_ld) res_q <= bus.eu_result_i;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start   = 1'b0;
        res_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_head) begin
                    if (head.killed) begin
                        pop = 1'b1;
                    end else if (head.committed) begin
                        start   = 1'b1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (bus.eu_done_i) begin
                    res_ld  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.result_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head cannot move during EXEC/RESP, so operands and result fields stay put.
    assign op_live            = start || (state_q == EXEC);
    assign rv                 = (state_q == RESP);
    assign bus.eu_start_o     = start;
    assign bus.eu_op_a_o      = op_live ? head.rs1 : '0;
    assign bus.eu_op_b_o      = op_live ? head.rs2 : '0;
    assign bus.result_valid_o = rv;
    assign bus.result_id_o    = rv ? head.id : '0;
    assign bus.result_rd_o    = rv ? head.rd : '0;
    assign bus.result_we_o    = rv && head.we;
    assign bus.result_data_o  = rv ? res_q : '0;
endmodule

// File: tb/tb_copro_exec_scheduler.sv
// Scoreboard bench: an in-order instruction list models the queue; starts and
// results are checked against it by monitors independent of the stimulus.
module tb_copro_exec_scheduler;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int ID_W  = 3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    copro_exec_if #(.XLEN(XLEN), .ID_W(ID_W)) bus ();
    copro_exec_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1, rs2;
        logic            we, committed, killed;
    } m_ent_t;
    typedef struct {
        logic [ID_W-1:0] id;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] data;
    } exp_t;

    m_ent_t mq[$];
    exp_t   exp_q[$];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int start_cnt = 0, start_cyc = -1, done_cyc = -1, rv_cyc = -1, hs_cyc = -1, res_cnt = 0;
    logic [ID_W-1:0] last_id = '0;
    logic [XLEN-1:0] last_data = '0;
    bit eu_auto = 1'b1, eu_busy = 1'b0, stale_req = 1'b0, prev_rv = 1'b0;
    int eu_delay = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [XLEN-1:0] eu_fn(logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        return a * b + XLEN'(20);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic bit pend();
        foreach (mq[i]) if (!mq[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    // Start/result monitor: the oldest non-killed instruction must be the one started.
    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.eu_start_o) begin
                start_cnt++;
                start_cyc = cyc;
                chk("start_during_resp", bus.result_valid_o, 0);
                while (mq.size() > 0 && mq[0].killed) void'(mq.pop_front());
                if (mq.size() == 0) fail_now("start_unexpected");
                else begin
                    chk("start_head_committed", mq[0].committed, 1);
                    chk("eu_op_a", bus.eu_op_a_o, mq[0].rs1);
                    chk("eu_op_b", bus.eu_op_b_o, mq[0].rs2);
                    exp_q.push_back('{id: mq[0].id, rd: mq[0].rd, we: mq[0].we,
                                      data: eu_fn(mq[0].rs1, mq[0].rs2)});
                    void'(mq.pop_front());
                end
            end
            if (bus.result_valid_o) begin
                if (!prev_rv) rv_cyc = cyc;
                if (exp_q.size() == 0) fail_now("result_unexpected");
                else begin
                    chk("result_id", bus.result_id_o, exp_q[0].id);
                    chk("result_rd", bus.result_rd_o, exp_q[0].rd);
                    chk("result_we", bus.result_we_o, exp_q[0].we);
                    chk("result_data", bus.result_data_o, exp_q[0].data);
                    if (bus.result_ready_i) begin
                        last_id   = exp_q[0].id;
                        last_data = exp_q[0].data;
                        void'(exp_q.pop_front());
                        hs_cyc = cyc;
                        res_cnt++;
                    end
                end
            end else begin
                chk("result_we_idle", bus.result_we_o, 0);
            end
            prev_rv = bus.result_valid_o;
        end
    end

    // Execution-unit model; also injects a stray done on request.
    initial begin
        logic [XLEN-1:0] a, b;
        int d;
        bus.eu_done_i   = 1'b0;
        bus.eu_result_i = '0;
        forever begin
            @(negedge clk_i);
            if (stale_req) begin
                @(posedge clk_i); #1;
                bus.eu_done_i   = 1'b1;
                bus.eu_result_i = 32'hDEAD_BEEF;
                @(posedge clk_i); #1;
                bus.eu_done_i   = 1'b0;
                bus.eu_result_i = '0;
                stale_req = 1'b0;
            end else if (rst_ni && bus.eu_start_o && eu_auto) begin
                eu_busy = 1'b1;
                a = bus.eu_op_a_o;
                b = bus.eu_op_b_o;
                d = (eu_delay != 0) ? eu_delay : int'($urandom_range(1, 4));
                repeat (d) @(posedge clk_i);
                #1;
                chk("eu_op_a_hold", bus.eu_op_a_o, a);
                chk("eu_op_b_hold", bus.eu_op_b_o, b);
                bus.eu_done_i   = 1'b1;
                bus.eu_result_i = eu_fn(a, b);
                done_cyc = cyc;
                @(posedge clk_i); #1;
                bus.eu_done_i   = 1'b0;
                bus.eu_result_i = '0;
                eu_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic step(input bit iv, input int id, input int rd, input logic [XLEN-1:0] r1,
                        input logic [XLEN-1:0] r2, input bit we, input bit cv, input int cid,
                        input bit ck, output bit acc);
        bus.issue_valid_i  = iv;
        bus.issue_id_i     = ID_W'(id);
        bus.issue_rd_i     = 5'(rd);
        bus.issue_rs1_i    = r1;
        bus.issue_rs2_i    = r2;
        bus.issue_we_i     = we;
        bus.commit_valid_i = cv;
        bus.commit_id_i    = ID_W'(cid);
        bus.commit_kill_i  = ck;
        @(negedge clk_i);
        acc = iv && bus.issue_ready_o;
        if (acc) mq.push_back('{id: ID_W'(id), rd: 5'(rd), rs1: r1, rs2: r2, we: we,
                                committed: 1'b0, killed: 1'b0});
        if (cv) foreach (mq[i]) if (mq[i].id == ID_W'(cid)) begin
            if (ck) mq[i].killed = 1'b1;
            else    mq[i].committed = 1'b1;
        end
        @(posedge clk_i); #1;
        bus.issue_valid_i  = 1'b0;
        bus.commit_valid_i = 1'b0;
    endtask

    task automatic nop();
        bit a;
        step(0, 0, 0, '0, '0, 0, 0, 0, 0, a);
    endtask

    task automatic issue(input int id, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                         output bit acc);
        step(1, id, id + 8, r1, r2, 1, 0, 0, 0, acc);
    endtask

    task automatic commit(input int id, input bit kill);
        bit a;
        step(0, 0, 0, '0, '0, 0, 1, id, kill, a);
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!pend() && exp_q.size() == 0 && !eu_busy && !bus.result_valid_o) begin
                ok = 1'b1;
                break;
            end
            nop();
        end
        if (!ok) fail_now({tag, "_drain_timeout"});
        repeat (5) nop();
        mq.delete();
        chk({tag, "_ready_after_drain"}, bus.issue_ready_o, 1);
    endtask

    initial begin
        bit acc, iv, cv, ck;
        int cid, s0, r0, commit_c, und[$];
        logic [ID_W-1:0] sv_id;
        logic [XLEN-1:0] sv_data;
        bus.issue_valid_i = 1'b0; bus.issue_id_i = '0; bus.issue_rd_i = '0;
        bus.issue_rs1_i = '0; bus.issue_rs2_i = '0; bus.issue_we_i = 1'b0;
        bus.commit_valid_i = 1'b0; bus.commit_id_i = '0; bus.commit_kill_i = 1'b0;
        bus.result_ready_i = 1'b1;

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_issue_ready", bus.issue_ready_o, 1);
        chk("rst_eu_start", bus.eu_start_o, 0);
        chk("rst_result_valid", bus.result_valid_o, 0);
        chk("rst_result_we", bus.result_we_o, 0);
        chk("rst_result_data", bus.result_data_o, 0);
        chk("rst_op_a", bus.eu_op_a_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        nop();

        // Single op with fixed EU latency
        eu_delay = 3;
        s0 = start_cnt; r0 = res_cnt;
        step(1, 1, 7, 32'd3, 32'd5, 1, 0, 0, 0, acc);
        chk("t1_accept", acc, 1);
        commit_c = cyc;
        commit(1, 0);
        wait_drain("t1");
        chk("t1_start_latency", start_cyc, commit_c + 1);
        chk("t1_result_latency", rv_cyc, done_cyc + 1);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_results", res_cnt - r0, 1);
        chk("t1_data", last_data, 32'h23);
        chk("t1_id", last_id, 1);
        eu_delay = 0;

        // Full queue
        for (int i = 0; i < 4; i++) begin
            issue(i, $urandom, $urandom, acc);
            chk("t2_accept", acc, 1);
        end
        chk("t2_ready_low", bus.issue_ready_o, 0);
        issue(4, 32'd1, 32'd1, acc);
        chk("t2_fifth_rejected", acc, 0);
        commit(0, 0);
        for (int k = 0; k < 60; k++) begin
            if (bus.issue_ready_o) break;
            nop();
        end
        chk("t2_ready_back", bus.issue_ready_o, 1);
        chk("t2_ready_timing", cyc, hs_cyc + 1);
        for (int i = 1; i < 4; i++) commit(i, 0);
        wait_drain("t2");

        // Kill
        s0 = start_cnt; r0 = res_cnt;
        issue(2, 32'd11, 32'd13, acc);
        issue(3, 32'd17, 32'd19, acc);
        commit(2, 1);
        commit(3, 0);
        wait_drain("t3");
        chk("t3_starts", start_cnt - s0, 1);
        chk("t3_results", res_cnt - r0, 1);
        chk("t3_last_id", last_id, 3);

        // Out-of-order commit keeps issue order
        s0 = start_cnt;
        issue(4, 32'd21, 32'd22, acc);
        issue(5, 32'd23, 32'd24, acc);
        commit(5, 0);
        repeat (3) nop();
        chk("t4_no_early_start", start_cnt - s0, 0);
        commit(4, 0);
        wait_drain("t4");
        chk("t4_starts", start_cnt - s0, 2);
        chk("t4_last_id", last_id, 5);

        // Backpressure, with commit in the same cycle as issue
        bus.result_ready_i = 1'b0;
        step(1, 6, 14, 32'd31, 32'd33, 1, 1, 6, 0, acc);
        step(1, 7, 15, 32'd35, 32'd37, 0, 1, 7, 0, acc);
        for (int k = 0; k < 30; k++) begin
            if (bus.result_valid_o) break;
            nop();
        end
        chk("t5_valid", bus.result_valid_o, 1);
        s0 = start_cnt;
        sv_id = bus.result_id_o;
        sv_data = bus.result_data_o;
        repeat (5) nop();
        chk("t5_valid_hold", bus.result_valid_o, 1);
        chk("t5_id_hold", bus.result_id_o, sv_id);
        chk("t5_data_hold", bus.result_data_o, sv_data);
        chk("t5_no_second_start", start_cnt - s0, 0);
        bus.result_ready_i = 1'b1;
        wait_drain("t5");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            und.delete();
            foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) und.push_back(i);
            bus.result_ready_i = ($urandom_range(0, 3) != 0);
            iv  = $urandom_range(0, 1);
            cv  = (und.size() > 0) && ($urandom_range(0, 2) == 0);
            cid = cv ? int'(mq[und[$urandom_range(0, und.size() - 1)]].id) : 0;
            ck  = ($urandom_range(0, 3) == 0);
            // Never kill an id whose live twin is already committed and may be starting.
            foreach (mq[i]) if (mq[i].id == ID_W'(cid) && mq[i].committed && !mq[i].killed) ck = 1'b0;
            step(iv, $urandom_range(0, 7), $urandom_range(0, 31), $urandom, $urandom,
                 $urandom_range(0, 1), cv, cid, ck, acc);
        end
        bus.result_ready_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            und.delete();
            foreach (mq[i]) if (!mq[i].committed && !mq[i].killed) und.push_back(i);
            if (und.size() == 0) break;
            commit(mq[und[0]].id, 0);
        end
        wait_drain("t6");

        // Reset during EXEC, then a stale done
        eu_auto = 1'b0;
        s0 = start_cnt;
        issue(1, 32'd9, 32'd9, acc);
        commit(1, 0);
        for (int k = 0; k < 10; k++) begin
            if (start_cnt != s0) break;
            nop();
        end
        chk("t7_started", start_cnt - s0, 1);
        nop();
        #2 rst_ni = 1'b0;
        #1;
        chk("t7_rst_ready", bus.issue_ready_o, 1);
        chk("t7_rst_start", bus.eu_start_o, 0);
        chk("t7_rst_valid", bus.result_valid_o, 0);
        chk("t7_rst_op_a", bus.eu_op_a_o, 0);
        chk("t7_rst_op_b", bus.eu_op_b_o, 0);
        chk("t7_rst_id", bus.result_id_o, 0);
        mq.delete();
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        s0 = start_cnt;
        stale_req = 1'b1;
        repeat (6) begin
            nop();
            chk("t7_no_valid", bus.result_valid_o, 0);
        end
        chk("t7_no_start", start_cnt - s0, 0);
        chk("t7_data_zero", bus.result_data_o, 0);
        chk("t7_ready", bus.issue_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
